// File: rtl/rr_bus_arbiter_if.sv
// Shared-bus bundle between four requesters and the round-robin arbiter.
// The master side drives requests and beat data; the slave side is the arbiter.
interface rr_bus_arbiter_if #(
    parameter int DW = 8
);
    logic [3:0]    req;
    logic [3:0]    last;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [DW-1:0] d3;
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          busy;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          timeout_evt;

    modport master (
        output req, last, d0, d1, d2, d3,
        input  gnt, sel, busy, data_out, data_valid, timeout_evt
    );

    modport slave (
        input  req, last, d0, d1, d2, d3,
        output gnt, sel, busy, data_out, data_valid, timeout_evt
    );
endinterface

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for a four-requester shared bus: multi-beat tenures,
// registered beat capture, and forced release after MAX_HOLD beats.
module rr_bus_arbiter #(
    parameter int DW       = 8,
    parameter int MAX_HOLD = 16
) (
    input logic           clk,
    input logic           rst_n,
    rr_bus_arbiter_if.slave bus
);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        GAP
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    sel_q, sel_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          to_q, to_d;

    logic [1:0]    winner;
    logic [1:0]    idx;
    logic          found;
    logic [DW-1:0] d_sel;
    logic          own_req;
    logic          own_last;
    logic          at_max;
    logic          release_c;

    // First requester at or after ptr, wrapping modulo 4.
    always_comb begin
        winner = ptr_q;
        found  = 1'b0;
        idx    = ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && bus.req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        case (sel_q)
            2'd0:    d_sel = bus.d0;
            2'd1:    d_sel = bus.d1;
            2'd2:    d_sel = bus.d2;
            default: d_sel = bus.d3;
        endcase
    end

    assign own_req   = bus.req[sel_q];
    assign own_last  = bus.last[sel_q];
    assign at_max    = (hold_q == HW'(MAX_HOLD));
    assign release_c = (own_req && own_last) || !own_req || at_max;

    // NOTE: every next-state signal gets a default before the case, so no
    // path through this block can leave a variable unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        data_d  = data_q;
        valid_d = valid_q;
        to_d    = 1'b0;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (|bus.req) begin
                    gnt_d   = 4'(1) << winner;
                    sel_d   = winner;
                    hold_d  = HW'(1);
                    busy_d  = 1'b1;
                    state_d = OWN;
                end
            end
            OWN: begin
                valid_d = own_req;
                if (own_req) begin
                    data_d = d_sel;
                end
                if (release_c) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = GAP;
                    ptr_d   = sel_q + 2'd1;
                    // A last landing on the final allowed beat is a normal completion.
                    to_d    = at_max && !(own_req && own_last);
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            GAP: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            to_q    <= to_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.sel         = sel_q;
    assign bus.busy        = busy_q;
    assign bus.data_out    = data_q;
    assign bus.data_valid  = valid_q;
    assign bus.timeout_evt = to_q;
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter (MAX_HOLD=8): table of per-edge vectors
// followed by a hand-written asynchronous mid-tenure reset sequence.
module tb_rr_bus_arbiter;
    localparam int DW = 8;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  last;
        logic [16:0] exp;   // {gnt, sel, busy, data_out, data_valid, timeout_evt}
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    vec_t vecs[$];

    rr_bus_arbiter_if #(.DW(DW)) bus ();

    rr_bus_arbiter #(.DW(DW), .MAX_HOLD(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] pack(input logic [3:0] g, input logic [1:0] s,
                                         input logic b, input logic [7:0] d,
                                         input logic v, input logic t);
        return {g, s, b, d, v, t};
    endfunction

    function automatic logic [16:0] observed();
        return pack(bus.gnt, bus.sel, bus.busy, bus.data_out, bus.data_valid, bus.timeout_evt);
    endfunction

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b sel=%0d busy=%b dout=%h dv=%b to=%b, want gnt=%b sel=%0d busy=%b dout=%h dv=%b to=%b",
                     name, act[16:13], act[12:11], act[10], act[9:2], act[1], act[0],
                     exp[16:13], exp[12:11], exp[10], exp[9:2], exp[1], exp[0]);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic [3:0] l, input logic [3:0] g,
                       input logic [1:0] s, input logic b, input logic [7:0] d,
                       input logic v, input logic t);
        vec_t x;
        x.req  = r;
        x.last = l;
        x.exp  = pack(g, s, b, d, v, t);
        vecs.push_back(x);
    endtask

    initial begin
        bus.req  = 4'b1111;
        bus.last = 4'b0000;
        bus.d0   = 8'hA1;
        bus.d1   = 8'hB2;
        bus.d2   = 8'hC3;
        bus.d3   = 8'hD4;

        // Round robin, one-beat tenures
        for (int k = 0; k < 5; k++) begin
            logic [1:0] o;
            logic [7:0] dv;
            o  = 2'(k);
            dv = (o == 2'd0) ? 8'hA1 : (o == 2'd1) ? 8'hB2 : (o == 2'd2) ? 8'hC3 : 8'hD4;
            add(4'b1111, 4'b1111, 4'(1) << o, o, 1'b1,
                (k == 0) ? 8'h00 : ((o == 2'd1) ? 8'hA1 : (o == 2'd2) ? 8'hB2 : (o == 2'd3) ? 8'hC3 : 8'hD4),
                1'b0, 1'b0);
            add(4'b1111, 4'b1111, 4'b0000, o, 1'b0, dv, 1'b1, 1'b0);
            add(4'b1111, 4'b1111, 4'b0000, o, 1'b0, dv, 1'b0, 1'b0);
        end
        // Rotation skip: owner 1 releases (ptr=2), then req=0011 picks 0
        add(4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 8'hA1, 1'b0, 1'b0);
        add(4'b0010, 4'b0010, 4'b0000, 2'd1, 1'b0, 8'hB2, 1'b1, 1'b0);
        add(4'b0011, 4'b0000, 4'b0000, 2'd1, 1'b0, 8'hB2, 1'b0, 1'b0);
        add(4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 8'hB2, 1'b0, 1'b0);
        add(4'b0011, 4'b0001, 4'b0000, 2'd0, 1'b0, 8'hA1, 1'b1, 1'b0);
        // Wrap: owner 3 releases to ptr=0, then req=1001 picks 0
        add(4'b1000, 4'b1000, 4'b0000, 2'd0, 1'b0, 8'hA1, 1'b0, 1'b0);
        add(4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 8'hA1, 1'b0, 1'b0);
        add(4'b1000, 4'b1000, 4'b0000, 2'd3, 1'b0, 8'hD4, 1'b1, 1'b0);
        add(4'b1001, 4'b0000, 4'b0000, 2'd3, 1'b0, 8'hD4, 1'b0, 1'b0);
        add(4'b1001, 4'b0000, 4'b0001, 2'd0, 1'b1, 8'hD4, 1'b0, 1'b0);
        add(4'b1001, 4'b0001, 4'b0000, 2'd0, 1'b0, 8'hA1, 1'b1, 1'b0);
        // Timeout: owner 2 holds for 8 beats without last
        add(4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b0, 8'hA1, 1'b0, 1'b0);
        add(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 8'hA1, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++)
            add(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 8'hC3, 1'b1, 1'b0);
        add(4'b0100, 4'b0000, 4'b0000, 2'd2, 1'b0, 8'hC3, 1'b1, 1'b1);
        add(4'b0110, 4'b0000, 4'b0000, 2'd2, 1'b0, 8'hC3, 1'b0, 1'b0);
        // ptr=3: req=0110 scans 3,0,1 -> owner 1; last on beat 8 is no timeout
        add(4'b0110, 4'b0000, 4'b0010, 2'd1, 1'b1, 8'hC3, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++)
            add(4'b0110, 4'b0000, 4'b0010, 2'd1, 1'b1, 8'hB2, 1'b1, 1'b0);
        add(4'b0110, 4'b0010, 4'b0000, 2'd1, 1'b0, 8'hB2, 1'b1, 1'b0);
        add(4'b1000, 4'b0000, 4'b0000, 2'd1, 1'b0, 8'hB2, 1'b0, 1'b0);
        // Request drop: owner 3 gives 3 beats then lowers req
        add(4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 8'hB2, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++)
            add(4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 8'hD4, 1'b1, 1'b0);
        add(4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 8'hD4, 1'b0, 1'b0);
        add(4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 8'hD4, 1'b0, 1'b0);
        add(4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 8'hD4, 1'b0, 1'b0);

        // Reset state while requests are pending
        #2;
        check("reset_initial", observed(), 17'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", observed(), 17'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            bus.req  = vecs[i].req;
            bus.last = vecs[i].last;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), observed(), vecs[i].exp);
            @(negedge clk);
        end

        // Reset mid-tenure: ptr=0 after the drop, owner 1 granted
        bus.req  = 4'b0010;
        bus.last = 4'b0000;
        @(posedge clk);
        #1;
        check("mid_grant", observed(), pack(4'b0010, 2'd1, 1'b1, 8'hD4, 1'b0, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        check("mid_beat2", observed(), pack(4'b0010, 2'd1, 1'b1, 8'hB2, 1'b1, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_async_reset", observed(), 17'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_grant", observed(), pack(4'b0010, 2'd1, 1'b1, 8'h00, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        check("post_reset_beat", observed(), pack(4'b0010, 2'd1, 1'b1, 8'hB2, 1'b1, 1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
